id_ex_fwd: RTL and testbench

ID_EX_FWD -- requirements
Module: id_ex_fwd

---
 rtl/id_ex_fwd_pkg.sv | 31 +++
 rtl/id_ex_fwd_fwd_cmp.sv | 30 +++
 rtl/id_ex_fwd.sv | 143 ++++++++++++++
 tb/tb_id_ex_fwd.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_fwd_pkg.sv
// Shared pipeline definitions for the ID/EX register and its forwarding logic:
// RV opcode constants, the canonical NOP and the forwarding-select codes.
package id_ex_fwd_pkg;

    localparam int XLEN = 64;

    // Major opcodes (inst[6:0]); kept here so every stage decodes from one list.
    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_e;

    // addi x0, x0, 0 -- what a killed EX slot shows downstream.
    localparam logic [31:0] NOP_INST = {12'd0, 5'd0, 3'd0, 5'd0, OPC_OP_IMM};

    // Operand source selected by the EX stage for rs1/rs2.
    typedef enum logic [1:0] {
        FWD_NONE   = 2'd0,  // register file value captured in ID
        FWD_MEMALU = 2'd1,  // ALU result now sitting in MEM
        FWD_WB     = 2'd2,  // value being written back this cycle
        FWD_LOAD   = 2'd3   // load data returning from memory
    } fwd_e;

endpackage

// File: rtl/id_ex_fwd_fwd_cmp.sv
// Forwarding comparator for one source register: checks the instruction
// leaving EX and the one in MEM, youngest producer wins, x0 never forwards.
module fwd_cmp
    import id_ex_fwd_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       ex_valid,
    input  logic       ex_we,
    input  logic [4:0] ex_rd,
    input  logic       ex_is_load,
    input  logic       mem_valid,
    input  logic       mem_we,
    input  logic [4:0] mem_rd,
    output logic [1:0] code
);

    // Priority select: EX entry is younger than the MEM shadow, so it is checked first.
    always_comb begin
        // NOTE: default assigned before any branch so no path leaves code unassigned (no latch).
        code = FWD_NONE;
        if (rs != 5'd0) begin
            if (ex_valid && ex_we && (ex_rd == rs)) begin
                code = ex_is_load ? FWD_LOAD : FWD_MEMALU;
            end else if (mem_valid && mem_we && (mem_rd == rs)) begin
                code = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/id_ex_fwd.sv
// ID/EX pipeline register with forwarding-select generation.
// Optional build macro IDEX_PERF_CNT_EN adds saturating bubble/stall counters.
module id_ex_fwd
    import id_ex_fwd_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    // ID stage
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [31:0]     id_inst,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [1:0]      id_alu_asel,
    input  logic [1:0]      id_alu_bsel,
    input  logic [4:0]      id_rd,
    input  logic            id_we,
    input  logic            id_is_load,
    // pipeline control
    input  logic            stall,
    input  logic            flush,
    // EX stage
    output logic            ex_valid,
    output logic [31:0]     EXinst,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] imm,
    output logic [1:0]      alu_asel,
    output logic [1:0]      alu_bsel,
    output logic [4:0]      ex_rd,
    output logic            ex_we,
    output logic            ex_is_load,
    output logic [1:0]      rs1_forwarding,
    output logic [1:0]      rs2_forwarding,
`ifdef IDEX_PERF_CNT_EN
    output logic [31:0]     bubble_cnt,
    output logic [31:0]     stall_cnt,
`endif
    output logic            id_ready
);

    logic [4:0] mem_rd;
    logic       mem_we;
    logic       mem_valid;
    logic [1:0] rs1_fwd_nxt;
    logic [1:0] rs2_fwd_nxt;

    assign id_ready = ~stall;

    fwd_cmp u_rs1_cmp (
        .rs         (id_inst[19:15]),
        .ex_valid   (ex_valid),
        .ex_we      (ex_we),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd),
        .code       (rs1_fwd_nxt)
    );

    fwd_cmp u_rs2_cmp (
        .rs         (id_inst[24:20]),
        .ex_valid   (ex_valid),
        .ex_we      (ex_we),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd),
        .code       (rs2_fwd_nxt)
    );

    // EX register and MEM shadow: advance when not stalled, flush or id_valid=0 load a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid       <= 1'b0;
            EXinst         <= NOP_INST;
            pc             <= '0;
            rs1            <= '0;
            rs2            <= '0;
            imm            <= '0;
            alu_asel       <= 2'b00;
            alu_bsel       <= 2'b00;
            ex_rd          <= 5'd0;
            ex_we          <= 1'b0;
            ex_is_load     <= 1'b0;
            rs1_forwarding <= FWD_NONE;
            rs2_forwarding <= FWD_NONE;
            mem_rd         <= 5'd0;
            mem_we         <= 1'b0;
            mem_valid      <= 1'b0;
        end else if (!stall) begin
            // NOTE: non-blocking so the MEM shadow takes the old EX values, not the ones loaded this edge.
            mem_rd    <= ex_rd;
            mem_we    <= ex_we;
            mem_valid <= ex_valid;
            pc        <= id_pc;
            rs1       <= id_rs1_data;
            rs2       <= id_rs2_data;
            imm       <= id_imm;
            ex_rd     <= id_rd;
            if (flush) begin
                ex_valid       <= 1'b0;
                EXinst         <= NOP_INST;
                alu_asel       <= 2'b00;
                alu_bsel       <= 2'b00;
                ex_we          <= 1'b0;
                ex_is_load     <= 1'b0;
                rs1_forwarding <= FWD_NONE;
                rs2_forwarding <= FWD_NONE;
            end else begin
                ex_valid       <= id_valid;
                EXinst         <= id_inst;
                alu_asel       <= id_alu_asel;
                alu_bsel       <= id_alu_bsel;
                ex_we          <= id_we & id_valid;
                ex_is_load     <= id_is_load & id_valid;
                rs1_forwarding <= id_valid ? rs1_fwd_nxt : FWD_NONE;
                rs2_forwarding <= id_valid ? rs2_fwd_nxt : FWD_NONE;
            end
        end
    end

`ifdef IDEX_PERF_CNT_EN
    // Saturating counters: bubbles loaded on advance, and cycles spent stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (stall) begin
                if (stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
            end else if (flush || !id_valid) begin
                if (bubble_cnt != 32'hFFFF_FFFF) bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_fwd.sv
// Self-checking bench for id_ex_fwd: directed hazard scenarios plus random
// traffic, checked by a scoreboard fed from a producer-history reference model.
`timescale 1ns/1ps
module tb_id_ex_fwd;

    typedef struct {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] rs1d;
        logic [63:0] rs2d;
        logic [63:0] imm;
        logic [1:0]  asel;
        logic [1:0]  bsel;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
    } id_t;

    typedef struct {
        logic        valid, we, is_load;
        logic [31:0] inst;
        logic [63:0] pc, rs1, rs2, imm;
        logic [1:0]  asel, bsel, f1, f2;
        logic [4:0]  rd;
        logic        chk_ctl;   // compare inst/is_load/asel/bsel
        logic        chk_data;  // compare pc/rs1/rs2/imm/rd
    } exp_t;

    typedef struct {
        logic       valid, we, is_load;
        logic [4:0] rd;
    } writer_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall = 1'b0;
    logic flush = 1'b0;
    id_t  cur;

    logic        ex_valid, ex_we, ex_is_load, id_ready;
    logic [31:0] EXinst;
    logic [63:0] pc, rs1, rs2, imm;
    logic [1:0]  alu_asel, alu_bsel, rs1_forwarding, rs2_forwarding;
    logic [4:0]  ex_rd;
`ifdef IDEX_PERF_CNT_EN
    logic [31:0] bubble_cnt, stall_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;
    int m_bubble = 0;
    int m_stall  = 0;

    exp_t    exp_q[$];
    exp_t    last_exp;
    writer_t hist[$];   // hist[0] = instruction now in EX, hist[1] = in MEM

    always #10 clk = ~clk;

    id_ex_fwd dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (cur.valid),
        .id_pc          (cur.pc),
        .id_inst        (cur.inst),
        .id_rs1_data    (cur.rs1d),
        .id_rs2_data    (cur.rs2d),
        .id_imm         (cur.imm),
        .id_alu_asel    (cur.asel),
        .id_alu_bsel    (cur.bsel),
        .id_rd          (cur.rd),
        .id_we          (cur.we),
        .id_is_load     (cur.ld),
        .stall          (stall),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .EXinst         (EXinst),
        .pc             (pc),
        .rs1            (rs1),
        .rs2            (rs2),
        .imm            (imm),
        .alu_asel       (alu_asel),
        .alu_bsel       (alu_bsel),
        .ex_rd          (ex_rd),
        .ex_we          (ex_we),
        .ex_is_load     (ex_is_load),
        .rs1_forwarding (rs1_forwarding),
        .rs2_forwarding (rs2_forwarding),
`ifdef IDEX_PERF_CNT_EN
        .bubble_cnt     (bubble_cnt),
        .stall_cnt      (stall_cnt),
`endif
        .id_ready       (id_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_out(input exp_t e, input string tag);
        check({tag, " ex_valid"}, ex_valid, e.valid);
        check({tag, " ex_we"}, ex_we, e.we);
        check({tag, " rs1_fwd"}, rs1_forwarding, e.f1);
        check({tag, " rs2_fwd"}, rs2_forwarding, e.f2);
        if (e.chk_ctl) begin
            check({tag, " EXinst"}, EXinst, e.inst);
            check({tag, " ex_is_load"}, ex_is_load, e.is_load);
            check({tag, " alu_asel"}, alu_asel, e.asel);
            check({tag, " alu_bsel"}, alu_bsel, e.bsel);
        end
        if (e.chk_data) begin
            check({tag, " pc"}, pc, e.pc);
            check({tag, " rs1"}, rs1, e.rs1);
            check({tag, " rs2"}, rs2, e.rs2);
            check({tag, " imm"}, imm, e.imm);
            check({tag, " ex_rd"}, ex_rd, e.rd);
        end
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e = '{valid: 1'b0, we: 1'b0, is_load: 1'b0, inst: 32'h0000_0013,
              pc: 64'd0, rs1: 64'd0, rs2: 64'd0, imm: 64'd0,
              asel: 2'd0, bsel: 2'd0, f1: 2'd0, f2: 2'd0, rd: 5'd0,
              chk_ctl: 1'b1, chk_data: 1'b1};
        return e;
    endfunction

    // Reference rule: the youngest in-flight writer of rs decides the source.
    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (rs == 5'd0) return 2'd0;
        for (int age = 0; age < hist.size() && age < 2; age++) begin
            if (hist[age].valid && hist[age].we && hist[age].rd == rs)
                return (age == 0) ? (hist[age].is_load ? 2'd3 : 2'd1) : 2'd2;
        end
        return 2'd0;
    endfunction

    function automatic logic [4:0] pick_reg();
        int k;
        k = $urandom_range(0, 4);
        return (k == 4) ? 5'd5 : 5'(k);
    endfunction

    function automatic id_t mk(input logic [31:0] inst, input logic we, input logic ld);
        id_t s;
        s.valid = 1'b1;
        s.inst  = inst;
        s.rd    = inst[11:7];
        s.we    = we;
        s.ld    = ld;
        s.pc    = {$urandom, $urandom};
        s.rs1d  = {$urandom, $urandom};
        s.rs2d  = {$urandom, $urandom};
        s.imm   = {$urandom, $urandom};
        s.asel  = 2'($urandom_range(0, 3));
        s.bsel  = 2'($urandom_range(0, 3));
        return s;
    endfunction

    function automatic id_t rand_id();
        id_t         s;
        logic [31:0] w;
        w        = $urandom;
        w[19:15] = pick_reg();
        w[24:20] = pick_reg();
        w[11:7]  = pick_reg();
        s        = mk(w, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
        s.valid  = $urandom_range(0, 9) != 0;
        return s;
    endfunction

    // Drive one cycle of ID/control inputs; record expectation on advance.
    task automatic step(input logic st, input logic fl, input id_t s);
        exp_t    e;
        writer_t w;
        @(negedge clk);
        cur   = s;
        stall = st;
        flush = fl;
        if (st) begin
            m_stall++;
        end else begin
            e = '{valid: 1'b0, we: 1'b0, is_load: 1'b0, inst: s.inst,
                  pc: s.pc, rs1: s.rs1d, rs2: s.rs2d, imm: s.imm,
                  asel: s.asel, bsel: s.bsel, f1: 2'd0, f2: 2'd0, rd: s.rd,
                  chk_ctl: 1'b0, chk_data: 1'b0};
            if (fl) begin
                e.inst    = 32'h0000_0013;
                e.asel    = 2'd0;
                e.bsel    = 2'd0;
                e.chk_ctl = 1'b1;
                m_bubble++;
            end else if (!s.valid) begin
                m_bubble++;
            end else begin
                e.valid    = 1'b1;
                e.we       = s.we;
                e.is_load  = s.ld;
                e.f1       = ref_fwd(s.inst[19:15]);
                e.f2       = ref_fwd(s.inst[24:20]);
                e.chk_ctl  = 1'b1;
                e.chk_data = 1'b1;
            end
            exp_q.push_back(e);
            w = '{valid: e.valid, we: e.we, is_load: e.is_load, rd: s.rd};
            hist.push_front(w);
            if (hist.size() > 2) void'(hist.pop_back());
        end
        @(posedge clk);
        #2;
    endtask

    task automatic reset_checks(input string tag);
        cmp_out(reset_exp(), tag);
`ifdef IDEX_PERF_CNT_EN
        check({tag, " bubble_cnt"}, bubble_cnt, 64'd0);
        check({tag, " stall_cnt"}, stall_cnt, 64'd0);
`endif
    endtask

    // Asynchronous reset pulse between clock edges (called just after a rising edge).
    task automatic pulse_reset();
        #1 rst = 1'b1;
        #1 reset_checks("async_rst");
        exp_q.delete();
        hist.delete();
        last_exp = reset_exp();
        m_bubble = 0;
        m_stall  = 0;
        #1 rst = 1'b0;
    endtask

    // Monitor: on every edge, an advance pops the next expectation, a stall re-checks the held one.
    initial begin
        logic adv;
        exp_t e;
        forever begin
            @(posedge clk);
            adv = id_ready && !rst;
            #1;
            if (!rst) begin
                if (adv) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL scoreboard: DUT advanced with no expectation at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        cmp_out(e, "adv");
                        last_exp = e;
                    end
                end else begin
                    cmp_out(last_exp, "hold");
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cur      = mk(32'h0000_0013, 1'b0, 1'b0);
        last_exp = reset_exp();
        @(posedge clk);
        #2 reset_checks("por");
        #3 rst = 1'b0;

        // addi x5 in EX, then add x6,x5,x7
        step(0, 0, mk(32'h0010_0293, 1'b1, 1'b0));
        step(0, 0, mk(32'h0072_8333, 1'b1, 1'b0));
        check("addi_add rs1_fwd", rs1_forwarding, 64'd1);
        check("addi_add rs2_fwd", rs2_forwarding, 64'd0);

        // lw x5 in EX, then sub x8,x1,x5
        step(0, 0, mk(32'h0005_2283, 1'b1, 1'b1));
        step(0, 0, mk(32'h4050_8433, 1'b1, 1'b0));
        check("lw_sub rs1_fwd", rs1_forwarding, 64'd0);
        check("lw_sub rs2_fwd", rs2_forwarding, 64'd3);

        // x5 in both EX and MEM -> EX wins
        step(0, 0, mk(32'h0010_0293, 1'b1, 1'b0));
        step(0, 0, mk(32'h0020_0293, 1'b1, 1'b0));
        step(0, 0, mk(32'h0052_84b3, 1'b1, 1'b0));
        check("both_hit rs1_fwd", rs1_forwarding, 64'd1);
        check("both_hit rs2_fwd", rs2_forwarding, 64'd1);

        // x5 only in MEM
        step(0, 0, mk(32'h0010_0293, 1'b1, 1'b0));
        step(0, 0, mk(32'h0020_8533, 1'b1, 1'b0));
        step(0, 0, mk(32'h0052_84b3, 1'b1, 1'b0));
        check("mem_only rs1_fwd", rs1_forwarding, 64'd2);
        check("mem_only rs2_fwd", rs2_forwarding, 64'd2);

        // x0 never forwards even with an EX writer of x0
        step(0, 0, mk(32'h0010_0013, 1'b1, 1'b0));
        step(0, 0, mk(32'h0000_00b3, 1'b1, 1'b0));
        check("x0 rs1_fwd", rs1_forwarding, 64'd0);
        check("x0 rs2_fwd", rs2_forwarding, 64'd0);

        // three stalled cycles with changing inputs, then stall+flush, then flush alone
        step(0, 0, mk(32'h0052_84b3, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++) step(1, 0, rand_id());
        step(1, 1, rand_id());
        check("stall_flush ex_valid", ex_valid, 64'd1);
        check("stall_flush EXinst", EXinst, 64'h0052_84b3);
        step(0, 1, rand_id());
        check("flush EXinst", EXinst, 64'h0000_0013);
        check("flush ex_valid", ex_valid, 64'd0);

        // reset in the middle of a stall, then the next advance loads ID inputs
        step(0, 0, mk(32'h0010_0293, 1'b1, 1'b0));
        step(1, 0, rand_id());
        pulse_reset();
        step(0, 0, mk(32'h0072_8333, 1'b1, 1'b0));
        check("post_rst EXinst", EXinst, 64'h0072_8333);
        check("post_rst rs1_fwd", rs1_forwarding, 64'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) pulse_reset();
            step($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, rand_id());
        end

`ifdef IDEX_PERF_CNT_EN
        check("bubble_cnt", bubble_cnt, 64'(m_bubble));
        check("stall_cnt", stall_cnt, 64'(m_stall));
`endif
        @(negedge clk);
        stall = 1'b1;
        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
